// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: handshake and data bus between the EX stage and the
// multiply/divide unit.
//
// Signals:
//    start    - operation request, sampled on the rising clock edge
//    ALUFn    - 6-bit R-type funct code, valid with start (and for MFHI/MFLO reads)
//    a, b     - rs / rt operands
//    flush    - abort request for an in-flight operation
//    busy     - iterative operation in progress, pipeline must stall
//    done     - one-cycle pulse when HI/LO were written by MULT/DIV
//    hi, lo   - architectural HI/LO registers
//    rd_data  - MFHI/MFLO read data (zero for any other code)
//
// Modports: master drives the request side (pipeline or testbench),
// slave is the multiply/divide unit.
interface mdu_hilo_if #(
   parameter int XLEN = 32
);

   logic            start;
   logic [5:0]      ALUFn;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] rd_data;

   modport master (
      output start, ALUFn, a, b, flush,
      input  busy, done, hi, lo, rd_data
   );

   modport slave (
      input  start, ALUFn, a, b, flush,
      output busy, done, hi, lo, rd_data
   );

endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO
// registers for the MIPS32 EX stage.
//
// Ports:
//    clk    - system clock, rising edge
//    reset  - asynchronous, active-high reset
//    bus    - mdu_hilo_if.slave (start/ALUFn/a/b/flush in,
//             busy/done/hi/lo/rd_data out)
//
// MULT/MULTU/DIV/DIVU take XLEN iteration cycles plus one sign-fix cycle;
// busy is high from the edge after start until the fix edge, and done
// pulses for the one cycle after HI/LO are written. MTHI/MTLO write in a
// single edge while idle; MFHI/MFLO are served combinationally on rd_data.
//
// Configuration macro MDU_ABORT_EN: when defined, flush aborts an in-flight
// operation (HI/LO keep their old values, no done) and suppresses a start
// presented while idle. When undefined, flush is ignored.
module mdu_hilo #(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     reset,
   mdu_hilo_if.slave bus
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MTHI = 6'b010001;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MTLO = 6'b010011;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   count_q;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;

   // Shared iteration registers: for multiply acc/low form the running
   // 2*XLEN product with low initially holding the multiplier and opnd the
   // multiplicand; for divide acc is the partial remainder, low shifts the
   // dividend out and the quotient in, opnd is the divisor.
   logic [XLEN-1:0] acc_q;
   logic [XLEN-1:0] low_q;
   logic [XLEN-1:0] opnd_q;
   logic            isDiv_q;
   logic            negRes_q;
   logic            negRem_q;
   logic            divZero_q;

   logic [XLEN-1:0]   acc_d;
   logic [XLEN-1:0]   low_d;
   logic [XLEN-1:0]   hiFix;
   logic [XLEN-1:0]   loFix;
   logic [XLEN:0]     mulSum;
   logic [XLEN:0]     divShift;
   logic [XLEN:0]     divDiff;
   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] productFix;

   logic            isMulDiv;
   logic            opSigned;
   logic            opDiv;
   logic [XLEN-1:0] absA;
   logic [XLEN-1:0] absB;
   logic            abortReq;

   // The abort request only exists when the feature is built in; otherwise
   // flush is tied off so every operation runs to completion.
`ifdef MDU_ABORT_EN
   assign abortReq = bus.flush;
`else
   logic unusedFlush;
   assign abortReq    = 1'b0;
   assign unusedFlush = bus.flush;
`endif

   // Decode of the funct code: 0110xx is the multiply/divide group, bit 1
   // selects divide and bit 0 selects the unsigned variant. Signed operands
   // are reduced to magnitudes so the iterative core is purely unsigned.
   always_comb begin
      isMulDiv = (bus.ALUFn[5:2] == 4'b0110);
      opDiv    = bus.ALUFn[1];
      opSigned = ~bus.ALUFn[0];
      absA     = (opSigned && bus.a[XLEN-1]) ? (~bus.a + 1'b1) : bus.a;
      absB     = (opSigned && bus.b[XLEN-1]) ? (~bus.b + 1'b1) : bus.b;
   end

   // One radix-2 step of either shift-add multiply or restoring division.
   // In division the top bit of divDiff is the borrow: set means the trial
   // subtraction went negative and the shifted remainder is kept instead.
   always_comb begin
      mulSum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
      divShift = {acc_q, low_q[XLEN-1]};
      divDiff  = divShift - {1'b0, opnd_q};
      acc_d    = mulSum[XLEN:1];
      low_d    = {mulSum[0], low_q[XLEN-1:1]};
      if (isDiv_q) begin
         if (!divDiff[XLEN]) begin
            acc_d = divDiff[XLEN-1:0];
            low_d = {low_q[XLEN-2:0], 1'b1};
         end else begin
            acc_d = divShift[XLEN-1:0];
            low_d = {low_q[XLEN-2:0], 1'b0};
         end
      end
   end

   // Sign correction applied on the FIX edge. A zero divisor bypasses the
   // arithmetic entirely: HI gets the raw dividend (parked in opnd at start)
   // and LO gets all ones. The DIV overflow case needs no special handling,
   // since negating the 0x80000000 magnitude quotient wraps to itself.
   always_comb begin
      product    = {acc_q, low_q};
      productFix = negRes_q ? (~product + 1'b1) : product;
      hiFix      = productFix[2*XLEN-1:XLEN];
      loFix      = productFix[XLEN-1:0];
      if (isDiv_q) begin
         if (divZero_q) begin
            hiFix = opnd_q;
            loFix = '1;
         end else begin
            loFix = negRes_q ? (~low_q + 1'b1) : low_q;
            hiFix = negRem_q ? (~acc_q + 1'b1) : acc_q;
         end
      end
   end

   // Control FSM with registered busy/done/HI/LO. Starts are only looked at
   // in IDLE, so anything presented while busy (MTHI/MTLO included) is
   // dropped. done is cleared on every edge unless the FIX edge sets it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         acc_q     <= '0;
         low_q     <= '0;
         opnd_q    <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && !abortReq) begin
                  if (isMulDiv) begin
                     state_q   <= CALC;
                     busy_q    <= 1'b1;
                     count_q   <= '0;
                     acc_q     <= '0;
                     isDiv_q   <= opDiv;
                     negRes_q  <= opSigned && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                     negRem_q  <= opSigned && opDiv && bus.a[XLEN-1];
                     divZero_q <= opDiv && (bus.b == '0);
                     if (opDiv) begin
                        low_q  <= absA;
                        opnd_q <= (bus.b == '0) ? bus.a : absB;
                     end else begin
                        low_q  <= absB;
                        opnd_q <= absA;
                     end
                  end else if (bus.ALUFn == FN_MTHI) begin
                     hi_q <= bus.a;
                  end else if (bus.ALUFn == FN_MTLO) begin
                     lo_q <= bus.a;
                  end
               end
            end
            CALC: begin
               if (abortReq) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q   <= acc_d;
                  low_q   <= low_d;
                  count_q <= count_q + CW'(1);
                  if (count_q == CW'(XLEN-1)) begin
                     state_q <= FIX;
                  end
               end
            end
            FIX: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (!abortReq) begin
                  hi_q   <= hiFix;
                  lo_q   <= loFix;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // MFHI/MFLO read port is purely combinational on the current code.
   always_comb begin
      bus.rd_data = '0;
      if (bus.ALUFn == FN_MFHI) begin
         bus.rd_data = hi_q;
      end else if (bus.ALUFn == FN_MFLO) begin
         bus.rd_data = lo_q;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
